// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard-unit bus: pipeline-side register/control info in, stall/flush/forward
// controls and performance counters out.
interface hazard_scoreboard_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic [AW-1:0]    rs1_d;
    logic [AW-1:0]    rs2_d;
    logic [AW-1:0]    rd_d;
    logic             long_d;
    logic [AW-1:0]    rs1_e;
    logic [AW-1:0]    rs2_e;
    logic [AW-1:0]    rd_e;
    logic             regwrite_e;
    logic             load_e;
    logic             long_e;
    logic             pc_src_e;
    logic [AW-1:0]    rd_m;
    logic             regwrite_m;
    logic [AW-1:0]    rd_w;
    logic             regwrite_w;
    logic             lu_done;
    logic [AW-1:0]    lu_rd;
    logic             mem_stall;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             lu_err;

    modport master (
        output rs1_d, rs2_d, rd_d, long_d,
        output rs1_e, rs2_e, rd_e, regwrite_e, load_e, long_e, pc_src_e,
        output rd_m, regwrite_m, rd_w, regwrite_w,
        output lu_done, lu_rd, mem_stall,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
        input  fwd_a_e, fwd_b_e, stall_cnt, flush_cnt, lu_err
    );

    modport slave (
        input  rs1_d, rs2_d, rd_d, long_d,
        input  rs1_e, rs2_e, rd_e, regwrite_e, load_e, long_e, pc_src_e,
        input  rd_m, regwrite_m, rd_w, regwrite_w,
        input  lu_done, lu_rd, mem_stall,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
        output fwd_a_e, fwd_b_e, stall_cnt, flush_cnt, lu_err
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: load-use and forwarding, a busy-register
// scoreboard for the out-of-order long-latency unit, data-memory wait freezes and
// saturating stall/flush counters.
module hazard_scoreboard_unit #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 16
) (
    input logic                    clk,
    input logic                    rst,
    hazard_scoreboard_unit_if.slave hz
);

    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_eff;
    logic [NREG-1:0]  lu_clr;
    logic [NREG-1:0]  issue_set;
    logic [3:0]       out_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             lu_err;

    logic             lw_stall;
    logic             sb_stall;
    logic             cap_stall;
    logic             dec_stall;
    logic             issue;
    logic             cnt_inc;
    logic             cnt_dec;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    // Forward source select for one E-stage operand; x0 is always read from the regfile.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic          wr_m,
        input logic [AW-1:0] dst_m,
        input logic          wr_w,
        input logic [AW-1:0] dst_w,
        input logic          done,
        input logic [AW-1:0] dst_lu
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (wr_m && dst_m == src) begin
                sel = 2'b10;
            end else if (wr_w && dst_w == src) begin
                sel = 2'b01;
            end else if (done && dst_lu == src) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // One-hot masks for the register retired and the register claimed this cycle.
    always_comb begin
        lu_clr    = '0;
        issue_set = '0;
        issue     = hz.long_e && hz.regwrite_e && (hz.rd_e != '0) && !hz.mem_stall;
        if (hz.lu_done) begin
            lu_clr[hz.lu_rd] = 1'b1;
        end
        if (issue) begin
            issue_set[hz.rd_e] = 1'b1;
        end
        busy_eff = busy & ~lu_clr;
    end

    // Decode-stage hazard detection: load-use, scoreboard (RAW and WAW) and in-flight cap.
    always_comb begin
        lw_stall  = hz.load_e && (hz.rd_e != '0) &&
                    ((hz.rd_e == hz.rs1_d) || (hz.rd_e == hz.rs2_d));
        sb_stall  = ((hz.rs1_d != '0) && busy_eff[hz.rs1_d]) ||
                    ((hz.rs2_d != '0) && busy_eff[hz.rs2_d]) ||
                    ((hz.rd_d  != '0) && busy_eff[hz.rd_d]);
        cap_stall = hz.long_d && (out_cnt == MAX_CNT) && !hz.lu_done;
        dec_stall = (lw_stall || sb_stall || cap_stall) && !hz.pc_src_e;
    end

    // Stage hold/flush controls; a memory wait freezes everything, reset bubbles D and E.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hz.mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else begin
            stall_f = dec_stall;
            stall_d = dec_stall;
            flush_d = hz.pc_src_e;
            flush_e = hz.pc_src_e || dec_stall;
        end
    end

    // Operand forwarding muxes for the E stage.
    always_comb begin
        fwd_a_e = fwd_sel(hz.rs1_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w,
                          hz.lu_done, hz.lu_rd);
        fwd_b_e = fwd_sel(hz.rs2_e, hz.regwrite_m, hz.rd_m, hz.regwrite_w, hz.rd_w,
                          hz.lu_done, hz.lu_rd);
    end

    assign cnt_inc = hz.long_e && !hz.mem_stall;
    assign cnt_dec = hz.lu_done;

    // Scoreboard, outstanding count, error flag and perf counters; a same-cycle set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_cnt   <= '0;
            lu_err    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            busy <= (busy & ~lu_clr) | issue_set;
            if (cnt_inc && !cnt_dec) begin
                if (out_cnt != MAX_CNT) begin
                    out_cnt <= out_cnt + 4'd1;
                end
            end else if (!cnt_inc && cnt_dec) begin
                if (out_cnt != 4'd0) begin
                    out_cnt <= out_cnt - 4'd1;
                end
            end
            if (cnt_dec && out_cnt == 4'd0) begin
                lu_err <= 1'b1;
            end
            if (stall_f && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_e && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign hz.stall_f   = stall_f;
    assign hz.stall_d   = stall_d;
    assign hz.stall_e   = stall_e;
    assign hz.stall_m   = stall_m;
    assign hz.flush_d   = flush_d;
    assign hz.flush_e   = flush_e;
    assign hz.fwd_a_e   = fwd_a_e;
    assign hz.fwd_b_e   = fwd_b_e;
    assign hz.stall_cnt = stall_cnt;
    assign hz.flush_cnt = flush_cnt;
    assign hz.lu_err    = lu_err;

endmodule
